key_conditioner: RTL

Input conditioner that turns a raw, asynchronous, bouncing push-button (board KEY, active-low) into a clean one-cycle `pulse` suitable for the `count` input of the display counter. It synchronizes, debounces, edge-detects, and optionally auto-repeats while the key is held. It sits directly upstream of the counter; `pulse` connects straight to the counter's `count` port.

---
 rtl/key_pkg.sv | 14 +
 rtl/synchronizer_2ff.sv | 26 ++
 rtl/key_conditioner.sv | 122 ++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the push-button conditioner.
package key_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_t;

    localparam logic KEY_RELEASED = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/synchronizer_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a configurable reset level.
module synchronizer_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_conditioner.sv
// Turns a raw active-low bouncing key into a clean one-cycle pulse plus a debounced level,
// with optional auto-repeat while the key stays held.
module key_conditioner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic pulse,
    output logic pressed
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_LIM   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] REP_DELAY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_PER   = CNT_W'(REPEAT_PERIOD);

    logic             key_sync;
    key_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] tmr_q;
    logic [CNT_W-1:0] tmr_d;
    logic [CNT_W-1:0] tmr_target;
    logic             rep_phase_q;
    logic             rep_hit;
    logic             pulse_q;
    logic             pressed_q;

    synchronizer_2ff #(
        .RESET_VAL(KEY_RELEASED)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d_i  (key_raw),
        .q_o  (key_sync)
    );

    // Both counters saturate instead of wrapping.
    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign tmr_d = (tmr_q == '1) ? tmr_q : tmr_q + CNT_W'(1);

    // The timer restarts at every repeat pulse; the first interval is the delay, later ones the period.
    assign tmr_target = rep_phase_q ? REP_PER : REP_DELAY;
    assign rep_hit    = (tmr_d == tmr_target);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmr_q       <= '0;
            rep_phase_q <= 1'b0;
            pulse_q     <= 1'b0;
            pressed_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_sync != KEY_RELEASED) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (key_sync == KEY_RELEASED) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LIM) begin
                        state_q     <= HELD;
                        pulse_q     <= 1'b1;
                        pressed_q   <= 1'b1;
                        tmr_q       <= '0;
                        rep_phase_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HELD: begin
                    if (key_sync == KEY_RELEASED) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= CNT_W'(1);
                    end else if (REPEAT_EN != 0) begin
                        if (rep_hit) begin
                            tmr_q       <= '0;
                            rep_phase_q <= 1'b1;
                            // Guards against back-to-back pulses when a period of 1 is configured.
                            pulse_q     <= !pulse_q;
                        end else begin
                            tmr_q <= tmr_d;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (key_sync != KEY_RELEASED) begin
                        state_q     <= HELD;
                        cnt_q       <= '0;
                        tmr_q       <= '0;
                        rep_phase_q <= 1'b0;
                    end else if (cnt_q == DEB_LIM) begin
                        state_q   <= IDLE;
                        pressed_q <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pulse   = pulse_q;
    assign pressed = pressed_q;

endmodule
